// File: rtl/seg7_scan_driver.sv
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Scans a 4-digit BCD value onto a common-anode, multiplexed
//            7-segment display. Segments and digit enables are active-low.
//            Each slot starts with a blank window against ghosting. Leading
//            zeros are optionally suppressed. The value is snapshotted once
//            per frame, so a frame never mixes two values.
// Options  : define SEG_DIM_EN to add the 3-bit 'dim' input. It gates the
//            active window with a free-running 3-bit PWM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
  parameter int SCAN_DIV  = 12500,
  parameter int BLANK_CYC = 250,
  parameter int LZ_BLANK  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
`ifdef SEG_DIM_EN
  input  logic [2:0]  dim,
`endif
  output logic [6:0]  seg,
  output logic [3:0]  dig_en,
  output logic        frame_tick
);

  localparam logic [15:0] c_LAST_CNT  = 16'(SCAN_DIV - 1);
  localparam logic [15:0] c_BLANK_CNT = 16'(BLANK_CYC);
  localparam logic [6:0]  c_SEG_OFF   = 7'h7F;
  localparam logic [3:0]  c_DIG_OFF   = 4'hF;

  logic [15:0] r_pcnt;
  logic [1:0]  r_dsel;
  logic [15:0] r_shadow;
  logic [6:0]  r_seg;
  logic [3:0]  r_dig_en;
  logic        r_frame_tick;

  logic        w_slot_end;
  logic        w_blank;
  logic        w_pwm_on;
  logic        w_lz_hide;
  logic        w_dark;
  logic [3:0]  w_nib;
  logic [3:0]  w_nib_zero;
  logic [3:0]  w_lead_zero;
  logic [6:0]  w_seg_next;
  logic [3:0]  w_dig_next;

  // BCD to active-low segments; anything outside 0..9 shows a dash (g only)
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    f_decode = 7'h40;
      4'd1:    f_decode = 7'h79;
      4'd2:    f_decode = 7'h24;
      4'd3:    f_decode = 7'h30;
      4'd4:    f_decode = 7'h19;
      4'd5:    f_decode = 7'h12;
      4'd6:    f_decode = 7'h02;
      4'd7:    f_decode = 7'h78;
      4'd8:    f_decode = 7'h00;
      4'd9:    f_decode = 7'h10;
      default: f_decode = 7'h3F;
    endcase
  endfunction

  assign w_slot_end = (r_pcnt == c_LAST_CNT);

  // With no blanking configured, the comparison disappears entirely
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign w_blank = 1'b0;
    end else begin : g_blank
      assign w_blank = (r_pcnt < c_BLANK_CNT);
    end
  endgenerate

`ifdef SEG_DIM_EN
  logic [2:0] r_pwm_cnt;

  // Free-running brightness PWM; the digit is lit while the count is <= dim
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm_cnt <= 3'd0;
    else        r_pwm_cnt <= r_pwm_cnt + 3'd1;
  end

  assign w_pwm_on = (r_pwm_cnt <= dim);
`else
  assign w_pwm_on = 1'b1;
`endif

  // Slot prescaler, digit select and per-frame snapshot of the input value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt       <= 16'd0;
      r_dsel       <= 2'd0;
      r_shadow     <= 16'h0000;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_slot_end && (r_dsel == 2'd3);
      if (w_slot_end) begin
        r_pcnt <= 16'd0;
        r_dsel <= r_dsel + 2'd1;
        if (r_dsel == 2'd3) r_shadow <= value;
      end else begin
        r_pcnt <= r_pcnt + 16'd1;
      end
    end
  end

  // Leading-zero detect: a digit is hidden when it and every digit above it are zero
  always_comb begin
    w_nib = r_shadow[{r_dsel, 2'b00} +: 4];
    for (int k = 0; k < 4; k++) begin
      w_nib_zero[k] = (r_shadow[4*k +: 4] == 4'd0);
    end
    w_lead_zero[3] = w_nib_zero[3];
    w_lead_zero[2] = w_nib_zero[3] & w_nib_zero[2];
    w_lead_zero[1] = w_nib_zero[3] & w_nib_zero[2] & w_nib_zero[1];
    w_lead_zero[0] = 1'b0;
    w_lz_hide      = (LZ_BLANK != 0) && w_lead_zero[r_dsel];
  end

  // Next display pattern: dark during blank, suppression or PWM-off, else the digit
  always_comb begin
    w_dark     = w_blank | w_lz_hide | ~w_pwm_on;
    w_seg_next = c_SEG_OFF;
    w_dig_next = c_DIG_OFF;
    if (!w_dark) begin
      w_seg_next = f_decode(w_nib);
      w_dig_next = ~(4'b0001 << r_dsel);
    end
  end

  // Registered pins so the display sees glitch-free, single-edge transitions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg    <= c_SEG_OFF;
      r_dig_en <= c_DIG_OFF;
    end else begin
      r_seg    <= w_seg_next;
      r_dig_en <= w_dig_next;
    end
  end

  assign seg        = r_seg;
  assign dig_en     = r_dig_en;
  assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Directed checks of seg7_scan_driver with SCAN_DIV=8, BLANK_CYC=2.
//            A second instance has leading-zero blanking off. Also builds with
//            SEG_DIM_EN, where dim is held at full brightness.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [6:0]  seg,  seg2;
  logic [3:0]  dig_en, dig_en2;
  logic        frame_tick, frame_tick2;
`ifdef SEG_DIM_EN
  logic [2:0]  dim;
`endif

  int unsigned pass_cnt;
  int unsigned total_cnt;
  int unsigned cyc;

  typedef struct {
    int unsigned cyc;
    logic [15:0] value;
    logic [6:0]  seg;
    logic [3:0]  den;
    logic        ft;
    logic        chk2;
    logic [6:0]  seg2;
    logic [3:0]  den2;
  } vec_t;

  vec_t vecs[$];

  seg7_scan_driver #(.SCAN_DIV(8), .BLANK_CYC(2), .LZ_BLANK(1)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
`ifdef SEG_DIM_EN
    .dim        (dim),
`endif
    .seg        (seg),
    .dig_en     (dig_en),
    .frame_tick (frame_tick)
  );

  seg7_scan_driver #(.SCAN_DIV(8), .BLANK_CYC(2), .LZ_BLANK(0)) u_nolz (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
`ifdef SEG_DIM_EN
    .dim        (dim),
`endif
    .seg        (seg2),
    .dig_en     (dig_en2),
    .frame_tick (frame_tick2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, required %h (cyc %0d)", name, act, exp, cyc);
  endtask

  // Advance to the falling edge after rising edge number n since reset release
  task automatic step_to(input int unsigned n);
    while (cyc < n) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
  endtask

  task automatic add(input int unsigned c, input logic [15:0] v, input logic [6:0] s,
                     input logic [3:0] d, input logic f, input logic c2,
                     input logic [6:0] s2, input logic [3:0] d2);
    vec_t t;
    t.cyc = c; t.value = v; t.seg = s; t.den = d; t.ft = f;
    t.chk2 = c2; t.seg2 = s2; t.den2 = d2;
    vecs.push_back(t);
  endtask

  int unsigned ft_cnt;
  int unsigned ft_first;
  int unsigned multi_low;

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    value     = 16'h1234;
`ifdef SEG_DIM_EN
    dim       = 3'd7;
`endif

    // cycle, value driven, seg, dig_en, frame_tick, check no-LZ?, seg2, dig_en2
    add(  1, 16'h1234, 7'h7F, 4'hF, 1'b0, 1'b1, 7'h7F, 4'hF);
    add(  2, 16'h1234, 7'h7F, 4'hF, 1'b0, 1'b0, 7'h7F, 4'hF);
    add(  3, 16'h1234, 7'h40, 4'hE, 1'b0, 1'b1, 7'h40, 4'hE);
    add(  8, 16'h1234, 7'h40, 4'hE, 1'b0, 1'b0, 7'h7F, 4'hF);
    add(  9, 16'h1234, 7'h7F, 4'hF, 1'b0, 1'b0, 7'h7F, 4'hF);
    add( 11, 16'h1234, 7'h7F, 4'hF, 1'b0, 1'b1, 7'h40, 4'hD);
    add( 31, 16'h1234, 7'h7F, 4'hF, 1'b0, 1'b0, 7'h7F, 4'hF);
    add( 32, 16'h1234, 7'h7F, 4'hF, 1'b1, 1'b0, 7'h7F, 4'hF);
    add( 33, 16'h1234, 7'h7F, 4'hF, 1'b0, 1'b0, 7'h7F, 4'hF);
    add( 34, 16'h1234, 7'h7F, 4'hF, 1'b0, 1'b0, 7'h7F, 4'hF);
    add( 35, 16'h1234, 7'h19, 4'hE, 1'b0, 1'b0, 7'h7F, 4'hF);
    add( 40, 16'h0070, 7'h19, 4'hE, 1'b0, 1'b0, 7'h7F, 4'hF);
    add( 43, 16'h0070, 7'h30, 4'hD, 1'b0, 1'b0, 7'h7F, 4'hF);
    add( 51, 16'h0070, 7'h24, 4'hB, 1'b0, 1'b0, 7'h7F, 4'hF);
    add( 59, 16'h0070, 7'h79, 4'h7, 1'b0, 1'b0, 7'h7F, 4'hF);
    add( 63, 16'h0070, 7'h79, 4'h7, 1'b0, 1'b0, 7'h7F, 4'hF);
    add( 64, 16'h0070, 7'h79, 4'h7, 1'b1, 1'b0, 7'h7F, 4'hF);
    add( 67, 16'h0070, 7'h40, 4'hE, 1'b0, 1'b1, 7'h40, 4'hE);
    add( 75, 16'h0070, 7'h78, 4'hD, 1'b0, 1'b1, 7'h78, 4'hD);
    add( 83, 16'h00A5, 7'h7F, 4'hF, 1'b0, 1'b1, 7'h40, 4'hB);
    add( 91, 16'h00A5, 7'h7F, 4'hF, 1'b0, 1'b1, 7'h40, 4'h7);
    add( 96, 16'h00A5, 7'h7F, 4'hF, 1'b1, 1'b0, 7'h7F, 4'hF);
    add( 99, 16'h00A5, 7'h12, 4'hE, 1'b0, 1'b0, 7'h7F, 4'hF);
    add(107, 16'h00A5, 7'h3F, 4'hD, 1'b0, 1'b1, 7'h3F, 4'hD);
    add(115, 16'h1111, 7'h7F, 4'hF, 1'b0, 1'b1, 7'h40, 4'hB);
    add(123, 16'h1111, 7'h7F, 4'hF, 1'b0, 1'b0, 7'h7F, 4'hF);
    add(131, 16'h1111, 7'h79, 4'hE, 1'b0, 1'b0, 7'h7F, 4'hF);
    add(135, 16'h2222, 7'h79, 4'hE, 1'b0, 1'b0, 7'h7F, 4'hF);
    add(139, 16'h2222, 7'h79, 4'hD, 1'b0, 1'b0, 7'h7F, 4'hF);
    add(147, 16'h2222, 7'h79, 4'hB, 1'b0, 1'b0, 7'h7F, 4'hF);
    add(155, 16'h2222, 7'h79, 4'h7, 1'b0, 1'b0, 7'h7F, 4'hF);
    add(160, 16'h2222, 7'h79, 4'h7, 1'b1, 1'b0, 7'h7F, 4'hF);
    add(163, 16'h2222, 7'h24, 4'hE, 1'b0, 1'b0, 7'h7F, 4'hF);
    add(171, 16'h2222, 7'h24, 4'hD, 1'b0, 1'b0, 7'h7F, 4'hF);
    add(191, 16'h2222, 7'h24, 4'h7, 1'b0, 1'b0, 7'h7F, 4'hF);
    add(192, 16'h9860, 7'h24, 4'h7, 1'b1, 1'b0, 7'h7F, 4'hF);
    add(195, 16'h9860, 7'h40, 4'hE, 1'b0, 1'b0, 7'h7F, 4'hF);
    add(203, 16'h9860, 7'h02, 4'hD, 1'b0, 1'b0, 7'h7F, 4'hF);
    add(211, 16'h9860, 7'h00, 4'hB, 1'b0, 1'b0, 7'h7F, 4'hF);
    add(219, 16'h9860, 7'h10, 4'h7, 1'b0, 1'b0, 7'h7F, 4'hF);

    // Reset held low for five clocks: outputs stay at their idle values
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_seg", 16'(seg), 16'h007F);
      chk("rst_dig_en", 16'(dig_en), 16'h000F);
      chk("rst_frame_tick", 16'(frame_tick), 16'h0000);
    end
    rst_n = 1'b1;
    cyc   = 0;

    // Table pass: value changes are applied just before advancing to each row
    for (int i = 0; i < vecs.size(); i++) begin
      value = vecs[i].value;
      step_to(vecs[i].cyc);
      chk($sformatf("seg@%0d", vecs[i].cyc), 16'(seg), 16'(vecs[i].seg));
      chk($sformatf("dig_en@%0d", vecs[i].cyc), 16'(dig_en), 16'(vecs[i].den));
      chk($sformatf("frame_tick@%0d", vecs[i].cyc), 16'(frame_tick), 16'(vecs[i].ft));
      if (vecs[i].chk2) begin
        chk($sformatf("nolz_seg@%0d", vecs[i].cyc), 16'(seg2), 16'(vecs[i].seg2));
        chk($sformatf("nolz_dig_en@%0d", vecs[i].cyc), 16'(dig_en2), 16'(vecs[i].den2));
      end
    end

    // Asynchronous reset mid-slot: outputs go idle between clock edges
    @(posedge clk);
    #2;
    chk("pre_async_seg", 16'(seg), 16'h0010);
    chk("pre_async_dig_en", 16'(dig_en), 16'h0007);
    rst_n = 1'b0;
    #1;
    chk("async_seg", 16'(seg), 16'h007F);
    chk("async_dig_en", 16'(dig_en), 16'h000F);
    chk("async_frame_tick", 16'(frame_tick), 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;

    // Post-reset: shadow is cleared, so the first frame shows a lone 0.
    // Count frame ticks over three frames and watch the one-digit rule.
    ft_cnt    = 0;
    ft_first  = 0;
    multi_low = 0;
    for (int unsigned n = 1; n <= 96; n++) begin
      step_to(n);
      if (frame_tick) begin
        ft_cnt++;
        if (ft_first == 0) ft_first = n;
      end
      if ($countones(~dig_en) > 1) multi_low++;
      if (n == 3) begin
        chk("post_rst_seg", 16'(seg), 16'h0040);
        chk("post_rst_dig_en", 16'(dig_en), 16'h000E);
      end
    end
    chk("frame_tick_count", 16'(ft_cnt), 16'd3);
    chk("frame_tick_first", 16'(ft_first), 16'd32);
    chk("multi_digit_low", 16'(multi_low), 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
